// File: rtl/plot_pkg.sv
// plot_pkg
// Shared constants and types for the square plot controller slice.
// Holds the VGA adapter field widths, the visible-area limits of the
// 160x120 frame, and the controller state enum.
package plot_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int C_W   = 3;

  localparam int X_MAX = 159;
  localparam int Y_MAX = 119;

  typedef enum logic [1:0] {
    IDLE,
    ERASE,
    DRAW,
    DONE
  } state_t;

endpackage

// File: rtl/square_plot_controller_if.sv
// square_plot_controller_if
// Move-request handshake between game logic and the plot controller.
//   req_valid  : requester holds a move request
//   req_x/y    : new top-left corner of the square
//   req_colour : colour to draw the square in
//   req_ready  : controller is idle and will take the request this edge
// master = requester (game logic), slave = square_plot_controller.
interface square_plot_controller_if import plot_pkg::*; ();

  logic           req_valid;
  logic [X_W-1:0] req_x;
  logic [Y_W-1:0] req_y;
  logic [C_W-1:0] req_colour;
  logic           req_ready;

  modport master (
    output req_valid,
    output req_x,
    output req_y,
    output req_colour,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_x,
    input  req_y,
    input  req_colour,
    output req_ready
  );

endinterface

// File: rtl/pixel_scan_counter.sv
// pixel_scan_counter
// Row-major SIZE x SIZE offset generator, dx fastest.
//   clk, reset : system clock, synchronous active-high reset
//   clear      : force dx = dy = 0 (takes priority over enable)
//   enable     : advance one pixel this cycle
//   dx, dy     : current offset inside the square
//   last       : current offset is the bottom-right pixel
// After the last pixel the counter wraps back to (0,0) on its own, so a
// second scan can follow directly without an explicit clear.
module pixel_scan_counter #(
  parameter int SIZE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  output logic [3:0] dx,
  output logic [3:0] dy,
  output logic       last
);

  localparam logic [3:0] LAST_IDX = 4'(SIZE - 1);

  assign last = (dx == LAST_IDX) && (dy == LAST_IDX);

  // Offset registers: dx runs across a row, the row end bumps dy, and the
  // final pixel wraps both back to zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      dx <= '0;
      dy <= '0;
    end else if (enable) begin
      if (dx == LAST_IDX) begin
        dx <= '0;
        dy <= (dy == LAST_IDX) ? 4'd0 : dy + 4'd1;
      end else begin
        dx <= dx + 4'd1;
      end
    end
  end

endmodule

// File: rtl/square_plot_controller.sv
// square_plot_controller
// Drives the single VGA adapter plot port for one moving SIZE x SIZE square.
// Each accepted move first repaints the previous square in BG_COLOUR, then
// paints the square at the new position. Pixels outside 160x120 still take
// a scan cycle but are not plotted.
//   clk, reset    : 50 MHz clock, synchronous active-high reset
//   req           : move-request handshake (slave side)
//   x, y, colour  : pixel address/colour to the adapter
//   plot          : adapter write strobe
//   busy          : an erase/draw sequence is in progress
//   done          : one-cycle pulse when a request has been fully drawn
module square_plot_controller import plot_pkg::*; #(
  parameter int             SIZE      = 4,
  parameter logic [C_W-1:0] BG_COLOUR = 3'b000
) (
  input  logic                     clk,
  input  logic                     reset,
  square_plot_controller_if.slave  req,
  output logic [X_W-1:0]           x,
  output logic [Y_W-1:0]           y,
  output logic [C_W-1:0]           colour,
  output logic                     plot,
  output logic                     busy,
  output logic                     done
);

  state_t state, state_next;

  logic [X_W-1:0] old_x, new_x;
  logic [Y_W-1:0] old_y, new_y;
  logic [C_W-1:0] new_colour;
  logic           has_old;

  logic [3:0]     dx, dy;
  logic           scan_last;
  logic           scan_clear;
  logic           scan_enable;
  logic           accept;
  logic           ready;

  logic [X_W-1:0] base_x;
  logic [Y_W-1:0] base_y;
  logic [X_W:0]   sx;
  logic [Y_W:0]   sy;
  logic           in_view;

  pixel_scan_counter #(.SIZE(SIZE)) u_scan (
    .clk    (clk),
    .reset  (reset),
    .clear  (scan_clear),
    .enable (scan_enable),
    .dx     (dx),
    .dy     (dy),
    .last   (scan_last)
  );

  // The erase pass walks the old square, every other state uses the new one.
  // The extra top bit keeps offsets past the right/bottom edge from wrapping
  // back into the visible area.
  assign base_x  = (state == ERASE) ? old_x : new_x;
  assign base_y  = (state == ERASE) ? old_y : new_y;
  assign sx      = {1'b0, base_x} + {5'b0, dx};
  assign sy      = {1'b0, base_y} + {4'b0, dy};
  assign in_view = (sx <= 9'(X_MAX)) && (sy <= 8'(Y_MAX));

  assign x             = sx[X_W-1:0];
  assign y             = sy[Y_W-1:0];
  assign req.req_ready = ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode. The scan counter is held at (0,0) while
  // idle; between ERASE and DRAW it wraps to (0,0) by itself.
  always_comb begin
    state_next  = state;
    scan_clear  = 1'b0;
    scan_enable = 1'b0;
    accept      = 1'b0;
    ready       = 1'b0;
    plot        = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    colour      = BG_COLOUR;
    case (state)
      IDLE: begin
        ready      = 1'b1;
        scan_clear = 1'b1;
        if (req.req_valid) begin
          accept     = 1'b1;
          state_next = has_old ? ERASE : DRAW;
        end
      end
      ERASE: begin
        busy        = 1'b1;
        scan_enable = 1'b1;
        plot        = in_view;
        if (scan_last) begin
          state_next = DRAW;
        end
      end
      DRAW: begin
        busy        = 1'b1;
        scan_enable = 1'b1;
        plot        = in_view;
        colour      = new_colour;
        if (scan_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Position registers. Request fields are captured only at the accept edge;
  // the finished square becomes the one to erase next time. Reset forgets
  // the old square, so whatever was partially drawn stays on screen.
  always_ff @(posedge clk) begin
    if (reset) begin
      new_x      <= '0;
      new_y      <= '0;
      new_colour <= BG_COLOUR;
      old_x      <= '0;
      old_y      <= '0;
      has_old    <= 1'b0;
    end else begin
      if (accept) begin
        new_x      <= req.req_x;
        new_y      <= req.req_y;
        new_colour <= req.req_colour;
      end
      if (state == DONE) begin
        old_x   <= new_x;
        old_y   <= new_y;
        has_old <= 1'b1;
      end
    end
  end

endmodule
